// File: rtl/axi4_ch_buf_pkg.sv
// Shared AXI4 channel payload widths, payload structs and pack/unpack helpers
// for axi4_ch_buf users.
package axi4_ch_buf_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_USER_W = 1;

    // AR/AW: id, addr, len(8), size(3), burst(2), lock(1), cache(4), prot(3), qos(4), region(4), user
    function automatic int unsigned ax_width(int unsigned id_w, int unsigned addr_w, int unsigned user_w);
        return id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + user_w;
    endfunction

    function automatic int unsigned w_width(int unsigned id_w, int unsigned data_w, int unsigned user_w);
        return id_w + data_w + data_w / 8 + user_w;
    endfunction

    function automatic int unsigned r_width(int unsigned id_w, int unsigned data_w, int unsigned user_w);
        return id_w + data_w + 2 + user_w;
    endfunction

    function automatic int unsigned b_width(int unsigned id_w, int unsigned user_w);
        return id_w + 2 + user_w;
    endfunction

    localparam int unsigned AX_PAYLOAD_W = ax_width(AXI_ID_W, AXI_ADDR_W, AXI_USER_W);
    localparam int unsigned W_PAYLOAD_W  = w_width(AXI_ID_W, AXI_DATA_W, AXI_USER_W);
    localparam int unsigned R_PAYLOAD_W  = r_width(AXI_ID_W, AXI_DATA_W, AXI_USER_W);
    localparam int unsigned B_PAYLOAD_W  = b_width(AXI_ID_W, AXI_USER_W);

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } b_payload_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } r_payload_t;

    function automatic logic [B_PAYLOAD_W-1:0] pack_b(input b_payload_t b);
        return B_PAYLOAD_W'(b);
    endfunction

    function automatic b_payload_t unpack_b(input logic [B_PAYLOAD_W-1:0] p);
        return b_payload_t'(p);
    endfunction

    function automatic logic [R_PAYLOAD_W-1:0] pack_r(input r_payload_t r);
        return R_PAYLOAD_W'(r);
    endfunction

    function automatic r_payload_t unpack_r(input logic [R_PAYLOAD_W-1:0] p);
        return r_payload_t'(p);
    endfunction

endpackage

// File: rtl/axi4_ch_buf_mem.sv
// Entry storage for axi4_ch_buf: register array with one write port and
// one asynchronous read port. Contents are not reset.
module axi4_ch_buf_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_ch_buf.sv
// Burst-aware elastic buffer for one AXI4 channel with occupancy and burst counts.
// Define AXI4_CH_BUF_PKT_MODE_EN for store-and-forward release of complete bursts.
module axi4_ch_buf
    import axi4_ch_buf_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [PAYLOAD_WIDTH-1:0] s_payload,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [PAYLOAD_WIDTH-1:0] m_payload,
    output logic                     m_last,
    output logic [CNT_WIDTH-1:0]     count,
    output logic [CNT_WIDTH-1:0]     burst_count
);

    localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
    localparam int unsigned ENTRY_WIDTH = PAYLOAD_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [PTR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PTR_WIDTH-1:0]   rd_ptr, rd_ptr_nxt;
    logic [CNT_WIDTH-1:0]   count_nxt, burst_nxt;
    logic                   s_ready_nxt, m_valid_nxt;
    logic                   push, pop;
    logic [ENTRY_WIDTH-1:0] head;

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    // Next-state for pointers, counters and the registered handshake flags
    always_comb begin
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        count_nxt   = count;
        burst_nxt   = burst_count;
        s_ready_nxt = 1'b0;
        m_valid_nxt = 1'b0;

        if (push) begin
            wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_WIDTH'(1);
        end

        case ({push, pop})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase

        case ({push & s_last, pop & m_last})
            2'b10:   burst_nxt = burst_count + ONE;
            2'b01:   burst_nxt = burst_count - ONE;
            default: burst_nxt = burst_count;
        endcase

        // Ready is a pure register so m_ready never reaches s_ready combinationally
        s_ready_nxt = (count_nxt != FULL);
`ifdef AXI4_CH_BUF_PKT_MODE_EN
        // Full-buffer fallback lets bursts longer than DEPTH drain instead of deadlocking
        m_valid_nxt = (count_nxt != '0) & ((burst_nxt != '0) | (count_nxt == FULL));
`else
        m_valid_nxt = (count_nxt != '0);
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            burst_count <= '0;
            s_ready     <= 1'b0;
            m_valid     <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            burst_count <= burst_nxt;
            s_ready     <= s_ready_nxt;
            m_valid     <= m_valid_nxt;
        end
    end

    axi4_ch_buf_mem #(
        .DEPTH      (DEPTH),
        .WIDTH      (ENTRY_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (aclk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({s_last, s_payload}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign m_last    = head[ENTRY_WIDTH-1];
    assign m_payload = head[PAYLOAD_WIDTH-1:0];

endmodule

// File: tb/tb_axi4_ch_buf.sv
// Directed self-checking bench for axi4_ch_buf (DEPTH=4, 64-bit payload);
// burst-release expectations follow AXI4_CH_BUF_PKT_MODE_EN when it is defined.
module tb_axi4_ch_buf;

    localparam int unsigned PW = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW = 3;
`ifdef AXI4_CH_BUF_PKT_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_payload;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [PW-1:0] m_payload;
    logic          m_last;
    logic [CW-1:0] count;
    logic [CW-1:0] burst_count;

    int n_cmp = 0;
    int n_err = 0;

    axi4_ch_buf #(
        .PAYLOAD_WIDTH (PW),
        .DEPTH         (DEPTH),
        .CNT_WIDTH     (CW)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_payload   (s_payload),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_payload   (m_payload),
        .m_last      (m_last),
        .count       (count),
        .burst_count (burst_count)
    );

    always #5 aclk = ~aclk;

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_last = 1'b1; s_payload = '0;
        tick();
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready_1: got %b want 0", s_ready); end
        tick();
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready_2: got %b want 0", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        areset = 1'b0;
        tick();
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL idle_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL idle_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (count !== CW'(0)) begin n_err++; $display("FAIL idle_count: got %0d want 0", count); end
        n_cmp++; if (burst_count !== CW'(0)) begin n_err++; $display("FAIL idle_burst: got %0d want 0", burst_count); end
    endtask

    task automatic test_fill_drain();
        logic [PW-1:0] exp;
        m_ready = 1'b0; s_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_payload = PW'(64'h11 * (i + 1));
            tick();
        end
        s_valid = 1'b0;
        n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL fill_count: got %0d want 4", count); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL fill_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (burst_count !== CW'(4)) begin n_err++; $display("FAIL fill_burst: got %0d want 4", burst_count); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = PW'(64'h11 * (i + 1));
            n_cmp++;
            if (m_valid !== 1'b1 || m_payload !== exp) begin
                n_err++; $display("FAIL drain_beat%0d: got v=%b %h want v=1 %h", i, m_valid, m_payload, exp);
            end
            tick();
        end
        m_ready = 1'b0;
        n_cmp++; if (count !== CW'(0)) begin n_err++; $display("FAIL drain_count: got %0d want 0", count); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL drain_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL drain_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_back_to_back();
        s_valid = 1'b1; m_ready = 1'b1; s_last = 1'b1;
        s_payload = PW'(64'h100);
        tick();
        for (int k = 1; k <= 16; k++) begin
            s_payload = PW'(64'h100 + k);
            if (k == 16) s_valid = 1'b0;
            n_cmp++;
            if (m_valid !== 1'b1 || m_payload !== PW'(64'h100 + k - 1) || count !== CW'(1)) begin
                n_err++;
                $display("FAIL stream_beat%0d: got v=%b %h cnt=%0d want v=1 %h cnt=1",
                         k - 1, m_valid, m_payload, count, PW'(64'h100 + k - 1));
            end
            tick();
        end
        m_ready = 1'b0;
        n_cmp++; if (count !== CW'(0)) begin n_err++; $display("FAIL stream_end_count: got %0d want 0", count); end
    endtask

    task automatic test_full_simul();
        m_ready = 1'b0; s_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_payload = PW'(64'hA0 + i);
            tick();
        end
        s_payload = PW'(64'hA4);
        m_ready = 1'b1;
        n_cmp++; if (s_ready !== 1'b0 || count !== CW'(4)) begin
            n_err++; $display("FAIL full_pre: got rdy=%b cnt=%0d want rdy=0 cnt=4", s_ready, count); end
        tick();
        n_cmp++; if (count !== CW'(3) || s_ready !== 1'b1) begin
            n_err++; $display("FAIL full_pop_only: got cnt=%0d rdy=%b want cnt=3 rdy=1", count, s_ready); end
        n_cmp++; if (m_payload !== PW'(64'hA1)) begin
            n_err++; $display("FAIL full_head: got %h want a1", m_payload); end
        m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        n_cmp++; if (count !== CW'(4) || s_ready !== 1'b0) begin
            n_err++; $display("FAIL full_late_push: got cnt=%0d rdy=%b want cnt=4 rdy=0", count, s_ready); end
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_payload !== PW'(64'hA0 + i)) begin
                n_err++; $display("FAIL full_drain%0d: got v=%b %h want v=1 %h", i, m_valid, m_payload, PW'(64'hA0 + i));
            end
            tick();
        end
        m_ready = 1'b0;
        n_cmp++; if (count !== CW'(0)) begin n_err++; $display("FAIL full_end_count: got %0d want 0", count); end
    endtask

    task automatic test_pkt_burst();
        logic          exp_v;
        logic [PW-1:0] exp_p [6];
        int            tx;
        int            rx;
        bit            pop_now;
        bit            push_now;
        exp_v = !PKT;
        m_ready = 1'b0;
        // 3-beat burst with idle gaps between beats
        for (int b = 0; b < 3; b++) begin
            s_valid = 1'b1; s_last = (b == 2); s_payload = PW'(64'hB0 + b);
            tick();
            s_valid = 1'b0;
            if (b < 2) begin
                n_cmp++;
                if (m_valid !== exp_v || count !== CW'(b + 1) || burst_count !== CW'(0)) begin
                    n_err++; $display("FAIL pkt3_partial%0d: got v=%b cnt=%0d bc=%0d want v=%b cnt=%0d bc=0",
                                      b, m_valid, count, burst_count, exp_v, b + 1);
                end
                tick();
                n_cmp++; if (m_valid !== exp_v) begin
                    n_err++; $display("FAIL pkt3_gap%0d: got v=%b want %b", b, m_valid, exp_v); end
            end
        end
        n_cmp++; if (m_valid !== 1'b1 || burst_count !== CW'(1) || count !== CW'(3)) begin
            n_err++; $display("FAIL pkt3_release: got v=%b bc=%0d cnt=%0d want v=1 bc=1 cnt=3", m_valid, burst_count, count); end
        m_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_payload !== PW'(64'hB0 + b) || m_last !== (b == 2)) begin
                n_err++; $display("FAIL pkt3_out%0d: got v=%b %h last=%b want v=1 %h last=%b",
                                  b, m_valid, m_payload, m_last, PW'(64'hB0 + b), (b == 2));
            end
            tick();
        end
        n_cmp++; if (burst_count !== CW'(0) || count !== CW'(0)) begin
            n_err++; $display("FAIL pkt3_end: got bc=%0d cnt=%0d want 0 0", burst_count, count); end

        // 6-beat burst longer than DEPTH must still drain via the full fallback
        m_ready = 1'b0;
        for (int b = 0; b < 6; b++) exp_p[b] = PW'(64'hC0 + b);
        for (int b = 0; b < 4; b++) begin
            s_valid = 1'b1; s_last = 1'b0; s_payload = exp_p[b];
            tick();
        end
        s_valid = 1'b0;
        n_cmp++; if (count !== CW'(4) || m_valid !== 1'b1 || burst_count !== CW'(0)) begin
            n_err++; $display("FAIL pkt6_fallback: got cnt=%0d v=%b bc=%0d want cnt=4 v=1 bc=0", count, m_valid, burst_count); end
        tx = 4; rx = 0; m_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
            s_valid = (tx < 6);
            s_payload = (tx < 6) ? exp_p[tx] : '0;
            s_last = (tx == 5);
            pop_now = m_valid;
            push_now = s_valid && s_ready;
            if (pop_now) begin
                n_cmp++;
                if (m_payload !== exp_p[rx] || m_last !== (rx == 5)) begin
                    n_err++; $display("FAIL pkt6_out%0d: got %h last=%b want %h last=%b",
                                      rx, m_payload, m_last, exp_p[rx], (rx == 5));
                end
            end
            tick();
            if (push_now) tx++;
            if (pop_now) rx++;
        end
        s_valid = 1'b0; m_ready = 1'b0; s_last = 1'b1;
        n_cmp++; if (rx != 6) begin n_err++; $display("FAIL pkt6_timeout: got %0d beats want 6", rx); end
        n_cmp++; if (count !== CW'(0) || burst_count !== CW'(0)) begin
            n_err++; $display("FAIL pkt6_end: got cnt=%0d bc=%0d want 0 0", count, burst_count); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0; s_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_payload = PW'(64'hDEAD0 + i);
            tick();
        end
        s_valid = 1'b0;
        n_cmp++; if (count !== CW'(2)) begin n_err++; $display("FAIL mid_pre_count: got %0d want 2", count); end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        n_cmp++; if (count !== CW'(0) || m_valid !== 1'b0 || burst_count !== CW'(0)) begin
            n_err++; $display("FAIL mid_reset: got cnt=%0d v=%b bc=%0d want 0 0 0", count, m_valid, burst_count); end
        tick();
        n_cmp++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_after: got rdy=%b v=%b want rdy=1 v=0", s_ready, m_valid); end
        s_valid = 1'b1; s_payload = PW'(64'h55);
        tick();
        s_valid = 1'b0;
        n_cmp++; if (m_valid !== 1'b1 || m_payload !== PW'(64'h55) || count !== CW'(1)) begin
            n_err++; $display("FAIL mid_fresh: got v=%b %h cnt=%0d want v=1 55 cnt=1", m_valid, m_payload, count); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        n_cmp++; if (count !== CW'(0) || m_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_end: got cnt=%0d v=%b want 0 0", count, m_valid); end
    endtask

    initial begin
        areset = 1'b1; s_valid = 1'b0; s_payload = '0; s_last = 1'b1; m_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_simul();
        test_pkt_burst();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
